// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto one word-addressed memory port.
// Optional: define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_abort,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic              d_size,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_abort,
  input  logic              priv,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_write,
  output logic              m_size,
  output logic [1:0]        m_prot,
  output logic [1:0]        m_trans,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_abort
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              grant_i, grant_d;
  logic              pend_v, pend_data, pend_store;

  assign addr_inc = last_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef MEM_ARB_RR_EN
  logic rr_last_data;

  // Ties go to whoever was not granted last; the record survives idle cycles.
  always_comb begin
    grant_d = n_reset & d_req & (~i_req | ~rr_last_data);
    grant_i = n_reset & i_req & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (!n_reset)     rr_last_data <= 1'b0;
    else if (grant_d) rr_last_data <= 1'b1;
    else if (grant_i) rr_last_data <= 1'b0;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       fetch_wins;

  // Reset gates the grants so nothing issues in a reset cycle.
  always_comb begin
    fetch_wins = i_req & (~d_req | (starve_cnt == STARVE_LIM));
    grant_i    = n_reset & fetch_wins;
    grant_d    = n_reset & d_req & ~fetch_wins;
  end

  always_ff @(posedge clk) begin
    if (!n_reset)                                 starve_cnt <= 4'd0;
    else if (!i_req || grant_i)                   starve_cnt <= 4'd0;
    else if (grant_d && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  always_comb begin
    state_d = IDLE;
    m_addr  = '0;
    m_wdata = '0;
    m_write = 1'b0;
    m_size  = 1'b0;
    m_prot  = 2'b00;
    m_trans = 2'b00;
    if (grant_d) begin
      state_d = DATA;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_write = d_write;
      m_size  = d_size;
      m_prot  = {priv, 1'b1};
    end else if (grant_i) begin
      state_d = FETCH;
      m_addr  = i_addr;
      m_prot  = {priv, 1'b0};
    end
    // SEQ only when the same owner continues at the next word.
    if (grant_d || grant_i)
      m_trans = (state_d == state_q && m_addr == addr_inc) ? 2'b11 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      last_addr  <= '0;
      pend_v     <= 1'b0;
      pend_data  <= 1'b0;
      pend_store <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (grant_i || grant_d) last_addr <= m_addr;
      pend_v     <= grant_i | grant_d;
      pend_data  <= grant_d;
      pend_store <= grant_d & d_write;
    end
  end

  // Memory data is already registered, so the response is a steered pass-through.
  always_comb begin
    i_valid = n_reset & pend_v & ~pend_data;
    d_valid = n_reset & pend_v & pend_data;
    i_rdata = i_valid ? m_rdata : '0;
    d_rdata = (d_valid && !pend_store) ? m_rdata : '0;
    i_abort = i_valid & m_abort;
    d_abort = d_valid & m_abort;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 1-cycle memory model and response scoreboard.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              i_req, d_req, d_write, d_size, priv;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_gnt, i_valid, i_abort, d_gnt, d_valid, d_abort;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_write, m_size;
  logic [1:0]        m_prot, m_trans;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_abort = 1'b0;
  logic              abort_arm;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        data;
    logic [31:0] rdata;
    logic        abort;
  } resp_t;
  resp_t resp_q[$];

  logic [31:0]   dmem    [0:1023];
  logic [1023:0] wr_flag = '0;
  logic [31:0]   exp_mem [0:1023];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_abort(i_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
    .d_size(d_size), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_abort(d_abort), .priv(priv),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_size(m_size),
    .m_prot(m_prot), .m_trans(m_trans), .m_rdata(m_rdata), .m_abort(m_abort)
  );

  function automatic logic [31:0] pat(input logic [9:0] a);
    return 32'hA5A5_0000 | {22'd0, a};
  endfunction

  // Memory device: registered read data and abort, one cycle after the transfer.
  always @(posedge clk) begin
    m_abort <= m_trans[1] & abort_arm;
    if (m_trans[1]) begin
      m_rdata <= wr_flag[m_addr[9:0]] ? dmem[m_addr[9:0]] : pat(m_addr[9:0]);
      if (m_write) begin
        dmem[m_addr[9:0]]    <= m_wdata;
        wr_flag[m_addr[9:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check issue side and any due response, queue the expected response.
  task automatic tick(input string tag, input logic eg_i, input logic eg_d, input logic [1:0] etr);
    resp_t       e;
    logic [31:0] a;
    @(negedge clk);
    chk({tag, ".i_gnt"}, i_gnt, eg_i);
    chk({tag, ".d_gnt"}, d_gnt, eg_d);
    chk({tag, ".m_trans"}, m_trans, etr);
    chk({tag, ".m_write"}, m_write, eg_d ? d_write : 1'b0);
    if (eg_i || eg_d) begin
      a = eg_d ? d_addr : i_addr;
      chk({tag, ".m_addr"}, m_addr, a);
      chk({tag, ".m_prot"}, m_prot, {priv, eg_d});
      if (eg_d) begin
        chk({tag, ".m_wdata"}, m_wdata, d_wdata);
        chk({tag, ".m_size"}, m_size, d_size);
      end
    end else begin
      chk({tag, ".m_addr_idle"}, m_addr, 0);
      chk({tag, ".m_prot_idle"}, m_prot, 0);
      chk({tag, ".m_wdata_idle"}, m_wdata, 0);
      chk({tag, ".m_size_idle"}, m_size, 0);
    end
    if (resp_q.size() > 0) begin
      e = resp_q.pop_front();
      chk({tag, ".i_valid"}, i_valid, !e.data);
      chk({tag, ".d_valid"}, d_valid, e.data);
      chk({tag, ".i_rdata"}, i_rdata, e.data ? 32'd0 : e.rdata);
      chk({tag, ".d_rdata"}, d_rdata, e.data ? e.rdata : 32'd0);
      chk({tag, ".i_abort"}, i_abort, !e.data && e.abort);
      chk({tag, ".d_abort"}, d_abort, e.data && e.abort);
    end else begin
      chk({tag, ".no_valid"}, {i_valid, d_valid, i_abort, d_abort}, 0);
    end
    if (eg_i || eg_d) begin
      a       = eg_d ? d_addr : i_addr;
      e.data  = eg_d;
      e.abort = abort_arm;
      if (eg_d && d_write) begin
        e.rdata = 32'd0;
        exp_mem[a[9:0]] = d_wdata;
      end else begin
        e.rdata = exp_mem[a[9:0]];
      end
      resp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) exp_mem[k] = pat(10'(k));
    n_reset = 1'b0; i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20;
    d_wdata = 32'h1234; d_write = 1'b1; d_size = 1'b1; priv = 1'b1; abort_arm = 1'b0;
    tick("rst0", 1'b0, 1'b0, 2'b00);
    tick("rst1", 1'b0, 1'b0, 2'b00);
    n_reset = 1'b1; d_req = 1'b0; d_write = 1'b0; d_size = 1'b0;

    // Sequential fetch stream
    i_addr = 32'd0; tick("f0", 1'b1, 1'b0, 2'b10);
    i_addr = 32'd1; tick("f1", 1'b1, 1'b0, 2'b11);
    i_addr = 32'd2; tick("f2", 1'b1, 1'b0, 2'b11);
    i_req = 1'b0;   tick("f_idle", 1'b0, 1'b0, 2'b00);

    // Data beats fetch on a tie
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h100;
    tick("tie_d", 1'b0, 1'b1, 2'b10);
    d_req = 1'b0; tick("tie_i", 1'b1, 1'b0, 2'b10);
    i_req = 1'b0; tick("tie_idle", 1'b0, 1'b0, 2'b00);

    // Starvation limit: 4 data grants, then fetch, then data resumes
    i_req = 1'b1; i_addr = 32'h50; d_req = 1'b1;
    d_addr = 32'h200; tick("st0", 1'b0, 1'b1, 2'b10);
    d_addr = 32'h201; tick("st1", 1'b0, 1'b1, 2'b11);
    d_addr = 32'h202; tick("st2", 1'b0, 1'b1, 2'b11);
    d_addr = 32'h203; tick("st3", 1'b0, 1'b1, 2'b11);
    d_addr = 32'h204; tick("st_fetch", 1'b1, 1'b0, 2'b10);
    i_req = 1'b0;     tick("st_resume", 1'b0, 1'b1, 2'b10);
    i_req = 1'b1; i_addr = 32'h60; d_addr = 32'h205;
    tick("st_cleared", 1'b0, 1'b1, 2'b11);
    d_req = 1'b0; tick("st_i2", 1'b1, 1'b0, 2'b10);
    i_req = 1'b0; tick("st_idle", 1'b0, 1'b0, 2'b00);

    // Store then load to the same word
    d_req = 1'b1; d_addr = 32'd5; d_wdata = 32'hDEADBEEF; d_write = 1'b1; d_size = 1'b1;
    tick("store", 1'b0, 1'b1, 2'b10);
    d_write = 1'b0; d_size = 1'b0; d_wdata = 32'h0;
    tick("load", 1'b0, 1'b1, 2'b10);
    d_req = 1'b0; tick("ld_idle", 1'b0, 1'b0, 2'b00);

    // Abort on a fetch response
    i_req = 1'b1; i_addr = 32'h30; abort_arm = 1'b1;
    tick("ab_issue", 1'b1, 1'b0, 2'b10);
    i_req = 1'b0; abort_arm = 1'b0;
    tick("ab_resp", 1'b0, 1'b0, 2'b00);

    // Address wrap counts as sequential
    i_req = 1'b1; i_addr = 32'hFFFF_FFFF; tick("wrap0", 1'b1, 1'b0, 2'b10);
    i_addr = 32'h0; tick("wrap1", 1'b1, 1'b0, 2'b11);
    i_req = 1'b0;   tick("wrap_idle", 1'b0, 1'b0, 2'b00);

    // Reset during a requesting cycle discards the transfer
    i_req = 1'b1; i_addr = 32'h31; n_reset = 1'b0;
    tick("mid_rst", 1'b0, 1'b0, 2'b00);
    n_reset = 1'b1; i_req = 1'b0;
    tick("post_rst", 1'b0, 1'b0, 2'b00);
    // last_addr and owner were cleared, so address 1 starts a new burst
    i_req = 1'b1; i_addr = 32'h1; tick("post_rst_f", 1'b1, 1'b0, 2'b10);
    i_req = 1'b0; tick("end_idle", 1'b0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
